// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronizes an async interrupt line, latches it as pending,
// and sequences trap entry (TAKE), handler residency and mret return (RET).
module intr_ctrl #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        INTR,
   input  logic        INSTR_DONE,
   input  logic        MRET,
   input  logic        CSR_MIE,
   input  logic [31:0] CSR_MTVEC,
   input  logic [31:0] CSR_MEPC,
   output logic        INT_TAKEN,
   output logic        TRAP_VALID,
   output logic [31:0] TRAP_PC,
   output logic        MIE_RESTORE,
   output logic        IN_HANDLER,
   output logic        PENDING,
   output logic [7:0]  MISSED_CNT
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned PC_W  = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAKE    = 2'd1,
      HANDLER = 2'd2,
      RET     = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_d_q, s_d_d;
   logic                   pending_q, pending_d;
   logic [CNT_W-1:0]       missed_q, missed_d;

   logic sync_out_c;
   logic event_c;
   logic enter_take_c;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         sync_q    <= '0;
         s_d_q     <= 1'b0;
         pending_q <= 1'b0;
         missed_q  <= '0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         s_d_q     <= s_d_d;
         pending_q <= pending_d;
         missed_q  <= missed_d;
      end
   end

   // Synchronizer chain, rising-edge detect, pending latch and saturating drop counter.
   always_comb begin
      sync_d       = {sync_q[SYNC_STAGES-2:0], INTR};
      sync_out_c   = sync_q[SYNC_STAGES-1];
      s_d_d        = sync_out_c;
      event_c      = sync_out_c & ~s_d_q;
      enter_take_c = (state_q == IDLE) & pending_q & CSR_MIE & INSTR_DONE;

      // A new edge arriving on the clearing edge keeps the flag set.
      pending_d = event_c | (pending_q & ~enter_take_c);

      missed_d = missed_q;
      if (event_c && pending_q && !enter_take_c && (missed_q != {CNT_W{1'b1}})) begin
         missed_d = missed_q + CNT_W'(1);
      end
   end

   // Next-state and Moore outputs; TRAP_PC passes the CSR value through in TAKE/RET.
   always_comb begin
      state_d     = state_q;
      INT_TAKEN   = 1'b0;
      TRAP_VALID  = 1'b0;
      TRAP_PC     = '0;
      MIE_RESTORE = 1'b0;
      IN_HANDLER  = 1'b0;

      case (state_q)
         IDLE: begin
            if (enter_take_c) begin
               state_d = TAKE;
            end
         end
         TAKE: begin
            INT_TAKEN  = 1'b1;
            TRAP_VALID = 1'b1;
            TRAP_PC    = PC_W'(CSR_MTVEC);
            state_d    = HANDLER;
         end
         HANDLER: begin
            IN_HANDLER = 1'b1;
            if (MRET) begin
               state_d = RET;
            end
         end
         RET: begin
            TRAP_VALID  = 1'b1;
            TRAP_PC     = PC_W'(CSR_MEPC);
            MIE_RESTORE = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign PENDING    = pending_q;
   assign MISSED_CNT = missed_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: behavioural model feeds a queue of expected
// trap transactions; a negedge monitor pops and compares whenever TRAP_VALID is seen.
module tb_intr_ctrl;

   localparam int N = 2;
   localparam int K_TAKE = 0;
   localparam int K_RET  = 1;
   localparam int M_IDLE = 0, M_TAKE = 1, M_HANDLER = 2, M_RET = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic        INTR, INSTR_DONE, MRET, CSR_MIE;
   logic [31:0] CSR_MTVEC, CSR_MEPC;
   logic        INT_TAKEN, TRAP_VALID, MIE_RESTORE, IN_HANDLER, PENDING;
   logic [31:0] TRAP_PC;
   logic [7:0]  MISSED_CNT;

   intr_ctrl #(.SYNC_STAGES(N)) dut (
      .CLK(CLK), .RST(RST), .INTR(INTR), .INSTR_DONE(INSTR_DONE), .MRET(MRET),
      .CSR_MIE(CSR_MIE), .CSR_MTVEC(CSR_MTVEC), .CSR_MEPC(CSR_MEPC),
      .INT_TAKEN(INT_TAKEN), .TRAP_VALID(TRAP_VALID), .TRAP_PC(TRAP_PC),
      .MIE_RESTORE(MIE_RESTORE), .IN_HANDLER(IN_HANDLER), .PENDING(PENDING),
      .MISSED_CNT(MISSED_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct { int kind; int cyc; } exp_t;
   exp_t exp_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural reference: INTR history, pending flag, drop count, trap mode.
   int cyc = 0;
   bit hist[$];
   int m_mode = M_IDLE;
   bit m_pend = 0;
   int m_missed = 0;

   initial begin
      bit ev, clr;
      for (int i = 0; i <= N; i++) hist.push_back(1'b0);
      forever begin
         @(posedge CLK);
         cyc++;
         if (RST) begin
            m_mode = M_IDLE; m_pend = 0; m_missed = 0;
            for (int i = 0; i <= N; i++) hist[i] = 1'b0;
         end else begin
            // hist[j] holds INTR as sampled j+1 edges ago; an edge is seen N edges after it was sampled
            ev  = hist[N-1] && !hist[N];
            clr = (m_mode == M_IDLE) && m_pend && CSR_MIE && INSTR_DONE;
            if (ev && m_pend && !clr && m_missed < 255) m_missed++;
            m_pend = ev || (m_pend && !clr);
            case (m_mode)
               M_IDLE:    if (clr) begin m_mode = M_TAKE; exp_q.push_back('{K_TAKE, cyc}); end
               M_TAKE:    m_mode = M_HANDLER;
               M_HANDLER: if (MRET) begin m_mode = M_RET; exp_q.push_back('{K_RET, cyc}); end
               default:   m_mode = M_IDLE;
            endcase
            hist.push_front(INTR);
            void'(hist.pop_back());
         end
      end
   end

   // Monitor: consumes expected transactions when the DUT presents a PC override.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RST) begin
            exp_q.delete();
            chk("reset_outputs", {INT_TAKEN, TRAP_VALID, TRAP_PC, MIE_RESTORE, IN_HANDLER, PENDING, MISSED_CNT}, 64'd0);
         end else begin
            if (TRAP_VALID) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_trap", TRAP_VALID, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("trap_cycle", 64'(cyc), 64'(e.cyc));
                  chk("int_taken", INT_TAKEN, 64'(e.kind == K_TAKE));
                  chk("mie_restore", MIE_RESTORE, 64'(e.kind == K_RET));
                  chk("trap_pc", TRAP_PC, (e.kind == K_TAKE) ? CSR_MTVEC : CSR_MEPC);
               end
            end else begin
               if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                  e = exp_q.pop_front();
                  chk("trap_missing", TRAP_VALID, 64'd1);
               end
               chk("quiet_outputs", {INT_TAKEN, MIE_RESTORE, TRAP_PC}, 64'd0);
            end
            chk("pending", PENDING, 64'(m_pend));
            chk("missed_cnt", MISSED_CNT, 64'(m_missed));
            chk("in_handler", IN_HANDLER, 64'(m_mode == M_HANDLER));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic pulse_intr();
      INTR = 1'b1; tick(1);
      INTR = 1'b0; tick(N + 2);
   endtask

   task automatic wait_handler(input int max);
      for (int i = 0; i < max && !IN_HANDLER; i++) tick(1);
      chk("handler_reached", IN_HANDLER, 64'd1);
   endtask

   task automatic do_mret();
      MRET = 1'b1; tick(1);
      MRET = 1'b0; tick(3);
   endtask

   initial begin
      int k, seen;
      RST = 1'b1; INTR = 0; INSTR_DONE = 0; MRET = 0; CSR_MIE = 0;
      CSR_MTVEC = 32'h0; CSR_MEPC = 32'h0;
      tick(3);
      RST = 1'b0;
      tick(3);

      // Minimum latency with MTVEC=0x100, then return to MEPC=0x2C
      CSR_MIE = 1; INSTR_DONE = 1; CSR_MTVEC = 32'h100; CSR_MEPC = 32'h2C;
      INTR = 1'b1;
      k = cyc + 1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         if (INT_TAKEN) seen = 1;
      end
      chk("take_latency", 64'(cyc), 64'(k + 3));
      tick(1);
      INTR = 1'b0;
      wait_handler(10);
      tick(3);
      do_mret();
      tick(3);

      // Pending held with MIE=0, taken once MIE returns
      CSR_MIE = 0; INSTR_DONE = 0;
      pulse_intr();
      tick(50);
      chk("pending_held", PENDING, 64'd1);
      CSR_MIE = 1; INSTR_DONE = 1;
      wait_handler(10);
      do_mret();

      // Saturating drop counter
      CSR_MIE = 0;
      for (int i = 0; i < 300; i++) pulse_intr();
      chk("missed_saturated", MISSED_CNT, 64'd255);
      CSR_MIE = 1;
      wait_handler(10);
      do_mret();

      // Event during handler: no nesting, taken after return
      CSR_MIE = 1; INSTR_DONE = 1;
      pulse_intr();
      wait_handler(10);
      pulse_intr();
      tick(5);
      chk("handler_pending", PENDING, 64'd1);
      do_mret();
      wait_handler(10);

      // Reset mid-handler with pending: abort, no return pulse
      pulse_intr();
      tick(2);
      RST = 1'b1;
      #1;
      chk("async_reset", {INT_TAKEN, TRAP_VALID, IN_HANDLER, PENDING, MIE_RESTORE}, 64'd0);
      tick(2);
      RST = 1'b0;
      tick(10);

      // INTR high across reset release yields exactly one trap
      INTR = 1'b1; RST = 1'b1;
      tick(2);
      RST = 1'b0;
      wait_handler(10);
      do_mret();
      tick(20);
      INTR = 1'b0;
      tick(5);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         CSR_MIE    = ($urandom_range(3) != 0);
         INSTR_DONE = ($urandom_range(2) == 0);
         MRET       = ($urandom_range(7) == 0);
         CSR_MTVEC  = $urandom;
         CSR_MEPC   = $urandom;
         if ($urandom_range(5) == 0) INTR = ~INTR;
         RST = ($urandom_range(999) == 0);
         tick(1);
      end
      RST = 0; MRET = 0; INTR = 0;
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
